// File: rtl/mem_bus_interface.sv
// Bus interface between the MIPS core memory-access control and an Avalon-MM master port.
// Optional waitrequest timeout abort is compiled in with `define BUS_TIMEOUT_EN.
module mem_bus_interface #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        core_req,
  input  logic        core_we,
  input  logic [1:0]  core_size,
  input  logic        core_unsigned,
  input  logic [31:0] core_addr,
  input  logic [31:0] core_wdata,
  output logic [31:0] core_rdata,
  output logic        core_stall,
  output logic        core_done,
  output logic        core_fault,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic        waitrequest,
  input  logic [31:0] readdata
);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t      state;
  logic [1:0]  lat_size;
  logic [1:0]  lat_off;
  logic        lat_uns;
  logic        req_legal;
  logic [3:0]  be_next;
  logic [31:0] wd_next;
  logic [31:0] load_ext;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;

`ifdef BUS_TIMEOUT_EN
  localparam int unsigned CW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CW-1:0] wait_cnt;
`endif

  assign core_stall = (state == ACCESS);

  always_comb begin
    req_legal = 1'b0;
    be_next   = '0;
    wd_next   = '0;
    case (core_size)
      2'b00: begin
        req_legal = 1'b1;
        be_next   = 4'b0001 << core_addr[1:0];
        wd_next   = {4{core_wdata[7:0]}};
      end
      2'b01: begin
        req_legal = ~core_addr[0];
        be_next   = core_addr[1] ? 4'b1100 : 4'b0011;
        wd_next   = {2{core_wdata[15:0]}};
      end
      2'b10: begin
        req_legal = (core_addr[1:0] == 2'b00);
        be_next   = 4'b1111;
        wd_next   = core_wdata;
      end
      default: req_legal = 1'b0;
    endcase
  end

  // Lane selection uses the offset latched at request time, not the live core address.
  always_comb begin
    lane_b   = readdata[8*lat_off +: 8];
    lane_h   = lat_off[1] ? readdata[31:16] : readdata[15:0];
    load_ext = readdata;
    case (lat_size)
      2'b00:   load_ext = {{24{~lat_uns & lane_b[7]}}, lane_b};
      2'b01:   load_ext = {{16{~lat_uns & lane_h[15]}}, lane_h};
      default: load_ext = readdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      read       <= 1'b0;
      write      <= 1'b0;
      core_done  <= 1'b0;
      core_fault <= 1'b0;
      address    <= '0;
      writedata  <= '0;
      core_rdata <= '0;
      byteenable <= '0;
      lat_size   <= '0;
      lat_off    <= '0;
      lat_uns    <= 1'b0;
`ifdef BUS_TIMEOUT_EN
      wait_cnt   <= '0;
`endif
    end else begin
      core_done  <= 1'b0;
      core_fault <= 1'b0;
      case (state)
        IDLE: begin
          if (core_req) begin
            if (req_legal) begin
              lat_size   <= core_size;
              lat_off    <= core_addr[1:0];
              lat_uns    <= core_unsigned;
              address    <= {core_addr[31:2], 2'b00};
              read       <= ~core_we;
              write      <= core_we;
              byteenable <= be_next;
              writedata  <= wd_next;
              state      <= ACCESS;
`ifdef BUS_TIMEOUT_EN
              wait_cnt   <= '0;
`endif
            end else begin
              core_fault <= 1'b1;
            end
          end
        end
        ACCESS: begin
          if (!waitrequest) begin
            read      <= 1'b0;
            write     <= 1'b0;
            core_done <= 1'b1;
            if (read) core_rdata <= load_ext;
            state     <= IDLE;
          end
`ifdef BUS_TIMEOUT_EN
          // This edge is the TIMEOUT_CYCLES-th wait cycle: abort instead of counting on.
          else if (wait_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
            read       <= 1'b0;
            write      <= 1'b0;
            core_fault <= 1'b1;
            state      <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_interface.sv
// Directed bench for mem_bus_interface; load results are scoreboarded against a queue.
module tb_mem_bus_interface;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        core_req = 1'b0;
  logic        core_we = 1'b0;
  logic [1:0]  core_size = 2'b00;
  logic        core_unsigned = 1'b0;
  logic [31:0] core_addr = '0;
  logic [31:0] core_wdata = '0;
  logic [31:0] core_rdata;
  logic        core_stall;
  logic        core_done;
  logic        core_fault;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic        waitrequest = 1'b0;
  logic [31:0] readdata = '0;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  logic [31:0] sb[$];

  mem_bus_interface #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset),
    .core_req(core_req), .core_we(core_we), .core_size(core_size),
    .core_unsigned(core_unsigned), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_rdata(core_rdata), .core_stall(core_stall), .core_done(core_done),
    .core_fault(core_fault), .address(address), .read(read), .write(write),
    .writedata(writedata), .byteenable(byteenable), .waitrequest(waitrequest),
    .readdata(readdata)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Presents one request for a single sampling edge; returns in cycle E+1.
  task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata);
    core_req      = 1'b1;
    core_we       = we;
    core_size     = size;
    core_unsigned = uns;
    core_addr     = addr;
    core_wdata    = wdata;
    tick();
    core_req      = 1'b0;
  endtask

  // Expects core_done exactly one cycle after waitrequest is released.
  task automatic wait_done(input bit is_load, input string tag);
    int unsigned lat = 0;
    bit got = 0;
    logic [31:0] exp;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      lat++;
      if (core_done) got = 1;
    end
    check({tag, " done"}, 32'(got), 32'd1);
    check({tag, " latency"}, lat, 32'd1);
    check({tag, " no fault with done"}, 32'(core_fault), 32'd0);
    if (got && is_load && sb.size() > 0) begin
      exp = sb.pop_front();
      check({tag, " rdata"}, core_rdata, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tick();
    tick();
    check("rst read", 32'(read), 32'd0);
    check("rst write", 32'(write), 32'd0);
    check("rst stall", 32'(core_stall), 32'd0);
    check("rst done", 32'(core_done), 32'd0);
    check("rst fault", 32'(core_fault), 32'd0);
    check("rst address", address, 32'd0);
    check("rst writedata", writedata, 32'd0);
    check("rst rdata", core_rdata, 32'd0);
    check("rst byteenable", 32'(byteenable), 32'd0);
    reset = 1'b0;
    tick();

    // Word load, zero-wait
    waitrequest = 1'b0;
    readdata = 32'hDEADBEEF;
    sb.push_back(32'hDEADBEEF);
    issue(1'b0, 2'b10, 1'b0, 32'h100, '0);
    check("wl read", 32'(read), 32'd1);
    check("wl write", 32'(write), 32'd0);
    check("wl address", address, 32'h100);
    check("wl be", 32'(byteenable), 32'hF);
    check("wl stall", 32'(core_stall), 32'd1);
    wait_done(1'b1, "wl");
    check("wl read dropped", 32'(read), 32'd0);
    check("wl stall dropped", 32'(core_stall), 32'd0);

    // Signed byte load with 3 wait cycles
    waitrequest = 1'b1;
    readdata = 32'h80123456;
    sb.push_back(32'hFFFFFF80);
    issue(1'b0, 2'b00, 1'b0, 32'h103, '0);
    check("sb be", 32'(byteenable), 32'h8);
    check("sb address", address, 32'h100);
    for (int i = 0; i < 3; i++) begin
      check("sb read held", 32'(read), 32'd1);
      check("sb stall held", 32'(core_stall), 32'd1);
      check("sb no early done", 32'(core_done), 32'd0);
      tick();
    end
    check("sb read 4th", 32'(read), 32'd1);
    waitrequest = 1'b0;
    wait_done(1'b1, "sb");

    // Unsigned byte load, same lane
    waitrequest = 1'b1;
    sb.push_back(32'h00000080);
    issue(1'b0, 2'b00, 1'b1, 32'h103, '0);
    for (int i = 0; i < 3; i++) tick();
    check("ub read 4th", 32'(read), 32'd1);
    waitrequest = 1'b0;
    wait_done(1'b1, "ub");

    // Signed half load, upper lane; back-to-back with an unsigned half load, lower lane
    readdata = 32'h80011234;
    sb.push_back(32'hFFFF8001);
    issue(1'b0, 2'b01, 1'b0, 32'h502, '0);
    check("sh be", 32'(byteenable), 32'hC);
    wait_done(1'b1, "sh");
    readdata = 32'h0000F234;
    sb.push_back(32'h0000F234);
    issue(1'b0, 2'b01, 1'b1, 32'h500, '0);
    check("uh back-to-back read", 32'(read), 32'd1);
    check("uh be", 32'(byteenable), 32'h3);
    wait_done(1'b1, "uh");

    // Half store
    issue(1'b1, 2'b01, 1'b0, 32'h202, 32'h0000ABCD);
    check("hs write", 32'(write), 32'd1);
    check("hs read", 32'(read), 32'd0);
    check("hs be", 32'(byteenable), 32'hC);
    check("hs writedata", writedata, 32'hABCDABCD);
    check("hs address", address, 32'h200);
    wait_done(1'b0, "hs");

    // Byte store, offset 1
    issue(1'b1, 2'b00, 1'b0, 32'h601, 32'h123456A5);
    check("bs be", 32'(byteenable), 32'h2);
    check("bs writedata", writedata, 32'hA5A5A5A5);
    wait_done(1'b0, "bs");

    // Illegal requests
    issue(1'b0, 2'b10, 1'b0, 32'h301, '0);
    check("mw fault", 32'(core_fault), 32'd1);
    check("mw read", 32'(read), 32'd0);
    check("mw write", 32'(write), 32'd0);
    check("mw stall", 32'(core_stall), 32'd0);
    check("mw done", 32'(core_done), 32'd0);
    tick();
    check("mw fault one-shot", 32'(core_fault), 32'd0);
    check("mw read after", 32'(read), 32'd0);
    issue(1'b1, 2'b01, 1'b0, 32'h201, 32'h1);
    check("mh fault", 32'(core_fault), 32'd1);
    check("mh write", 32'(write), 32'd0);
    tick();
    issue(1'b0, 2'b11, 1'b0, 32'h300, '0);
    check("rsv fault", 32'(core_fault), 32'd1);
    check("rsv stall", 32'(core_stall), 32'd0);
    tick();

    // Reset mid-transfer
    waitrequest = 1'b1;
    issue(1'b0, 2'b10, 1'b0, 32'h400, '0);
    tick();
    check("rm read before", 32'(read), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rm read", 32'(read), 32'd0);
    check("rm stall", 32'(core_stall), 32'd0);
    check("rm done", 32'(core_done), 32'd0);
    waitrequest = 1'b0;
    tick();
    check("rm no late done", 32'(core_done), 32'd0);
    readdata = 32'h12345678;
    sb.push_back(32'h12345678);
    issue(1'b0, 2'b10, 1'b0, 32'h404, '0);
    check("rm2 address", address, 32'h404);
    wait_done(1'b1, "rm2");

`ifdef BUS_TIMEOUT_EN
    waitrequest = 1'b1;
    issue(1'b0, 2'b10, 1'b0, 32'h700, '0);
    for (int i = 0; i < 4; i++) begin
      check("to read held", 32'(read), 32'd1);
      check("to no fault yet", 32'(core_fault), 32'd0);
      tick();
    end
    check("to read dropped", 32'(read), 32'd0);
    check("to fault", 32'(core_fault), 32'd1);
    check("to done", 32'(core_done), 32'd0);
    check("to stall", 32'(core_stall), 32'd0);
    check("to rdata kept", core_rdata, 32'h12345678);
    tick();
    check("to fault one-shot", 32'(core_fault), 32'd0);
    waitrequest = 1'b0;
`endif

    check("scoreboard drained", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
